// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants, queue-count encoding and redirect helpers for the fetch unit
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int FETCH_W = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef enum logic [1:0] {
    QCNT_EMPTY = 2'd0,
    QCNT_ONE   = 2'd1,
    QCNT_FULL  = 2'd2
  } qcnt_e;

  // beq displacement: sign-extended imm16 scaled to a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// rtl/instr_fetch_unit_queue.sv - fetch_queue2: two-entry {word, pc} FIFO with push/pop and tail flush
module fetch_queue2
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [FETCH_W-1:0] push_word,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush_tail,
  output qcnt_e              count,
  output logic [FETCH_W-1:0] head_word,
  output logic [ADDR_W-1:0]  head_pc
);

  qcnt_e              cnt_q;
  logic [FETCH_W-1:0] word_q [2];
  logic [ADDR_W-1:0]  pc_q   [2];
  logic [1:0]         kept;
  logic [1:0]         after_pop;
  logic               push_ok;

  // Tail flush is applied first, then the pop, then the push lands behind what survives
  always_comb begin
    kept      = (flush_tail && cnt_q == QCNT_FULL) ? 2'd1 : 2'(cnt_q);
    after_pop = (pop && kept != 2'd0) ? kept - 2'd1 : kept;
    push_ok   = push && (after_pop != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= QCNT_EMPTY;
      word_q[0] <= '0;
      word_q[1] <= '0;
      pc_q[0]   <= RESET_PC;
      pc_q[1]   <= RESET_PC;
    end else begin
      if (pop && kept == 2'd2) begin
        word_q[0] <= word_q[1];
        pc_q[0]   <= pc_q[1];
      end
      if (push_ok) begin
        if (after_pop == 2'd0) begin
          word_q[0] <= push_word;
          pc_q[0]   <= push_pc;
        end else begin
          word_q[1] <= push_word;
          pc_q[1]   <= push_pc;
        end
      end
      cnt_q <= qcnt_e'(after_pop + {1'b0, push_ok});
    end
  end

  assign count     = cnt_q;
  assign head_word = word_q[0];
  assign head_pc   = pc_q[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, imem request/response control and jump/beq redirect for the decode slot
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [FETCH_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [FETCH_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               jump,
  input  logic               branch,
  input  logic               alu_zero
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  req_pc_q;
  logic               outstanding_q;
  logic               kill_q;
  logic               started_q;

  qcnt_e              q_count;
  logic [FETCH_W-1:0] head_word;
  logic [ADDR_W-1:0]  head_pc;

  logic               accept;
  logic               taken;
  logic               fire;
  logic               rsp;
  logic               push;
  logic               outstanding_next;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  jump_target;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  redirect_pc;

  fetch_queue2 #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_ADDR)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_word  (imem_rdata),
    .push_pc    (req_pc_q),
    .pop        (accept),
    .flush_tail (taken),
    .count      (q_count),
    .head_word  (head_word),
    .head_pc    (head_pc)
  );

  assign instr_valid = (q_count != QCNT_EMPTY);
  assign accept      = instr_valid & instr_ready;
  assign taken       = accept & (jump | (branch & alu_zero));

  // Only one request may be in flight, so the occupancy limit reduces to "queue not full"
  assign imem_req  = started_q & ~outstanding_q & (q_count != QCNT_FULL);
  assign imem_addr = fetch_pc_q;
  assign fire      = imem_req & imem_gnt;
  assign rsp       = imem_rvalid & outstanding_q;
  assign push      = rsp & ~kill_q & ~taken;

  assign outstanding_next = fire | (outstanding_q & ~rsp);

  always_comb begin
    pc_plus4          = head_pc + ADDR_W'(4);
    jump_target       = pc_plus4;
    jump_target[27:0] = {head_word[25:0], 2'b00};
    branch_target     = pc_plus4 + ADDR_W'(branch_offset(head_word[15:0]));
    redirect_pc       = jump ? jump_target : branch_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_ADDR;
      req_pc_q      <= RESET_ADDR;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      started_q     <= 1'b1;
      outstanding_q <= outstanding_next;
      if (fire) begin
        req_pc_q <= fetch_pc_q;
      end
      // A redirect wins over the grant increment; any request left in flight is stale
      if (taken) begin
        fetch_pc_q <= redirect_pc;
        kill_q     <= outstanding_next;
      end else begin
        if (fire) begin
          fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
        end
        if (rsp) begin
          kill_q <= 1'b0;
        end
      end
    end
  end

  assign instr    = head_word;
  assign instr_pc = head_pc;
  assign opcode   = head_word[OPCODE_MSB:OPCODE_LSB];
  assign funct    = head_word[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench: architectural instruction-stream model vs fetch unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] instr_pc;
  logic        jump;
  logic        branch;
  logic        alu_zero;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct(funct), .instr_pc(instr_pc),
    .jump(jump), .branch(branch), .alu_zero(alu_zero)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory image: overrides for directed programs, hashed words elsewhere
  logic [31:0] ovr [logic [31:0]];
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                          input logic j, input logic b, input logic z);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return {seq[31:28], w[25:0], 2'b00};
    if (b && z) return seq + {{14{w[15]}}, w[15:0], 2'b00};
    return seq;
  endfunction

  typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;
  exp_t sbq[$];

  int rdy_mode = 0;     // 0 ready, 1 stalled, 2 random
  int ctrl_mode = 0;    // 0 none, 1 decode overrides, 2 random
  int gnt_delay = 0;    // <0 random 0..3
  int rsp_lat = 1;      // 0 random 1..4
  int accepts = 0;
  int grants = 0;
  bit beq_done = 0;
  bit seq_chk = 0;
  bit saw_target = 0;
  bit pend = 0;
  logic [31:0] seq_addr;

  // Decode-side stimulus: whenever an accept is driven, the reference stream supplies the expectation
  initial begin
    logic [31:0] model_pc;
    logic [31:0] w;
    logic [31:0] jaddr;
    bit armed;
    model_pc = RPC; armed = 0; jaddr = '0;
    instr_ready = 0; jump = 0; branch = 0; alu_zero = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        model_pc = RPC; sbq.delete(); armed = 0;
        instr_ready = 0; jump = 0; branch = 0; alu_zero = 0;
        continue;
      end
      if (armed) begin
        chk("jump_imem_addr", imem_addr, jaddr);
        armed = 0;
      end
      instr_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom % 4 != 0);
      w = mem(model_pc);
      case (ctrl_mode)
        1: begin
          jump     = ovr.exists(model_pc) && w[31:26] == 6'd2;
          branch   = ovr.exists(model_pc) && w[31:26] == 6'd4;
          alu_zero = !beq_done;
        end
        2: begin
          jump     = ($urandom % 8 == 0);
          branch   = ($urandom % 3 == 0);
          alu_zero = $urandom % 2;
        end
        default: begin
          jump = 0; branch = 0; alu_zero = $urandom % 2;
        end
      endcase
      if (instr_valid && instr_ready) begin
        sbq.push_back('{model_pc, w});
        if (ctrl_mode == 1 && branch) beq_done = 1;
        model_pc = next_pc(model_pc, w, jump, branch, alu_zero);
        if (ctrl_mode == 1 && jump) begin
          armed = 1; jaddr = model_pc;
        end
        accepts++;
      end
    end
  end

  // Instruction memory: configurable grant delay and in-order response latency
  initial begin
    logic [31:0] paddr;
    int pwait, gcnt, gtarget;
    bit waiting;
    paddr = '0; pwait = 0; gcnt = 0; gtarget = 0; waiting = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
      if (!rst_n) begin
        pend = 0; waiting = 0; gcnt = 0;
        continue;
      end
      if (pend) begin
        chk("single_outstanding", imem_req, 1'b0);
        if (pwait == 0) begin
          imem_rvalid = 1; imem_rdata = mem(paddr); pend = 0;
        end else pwait--;
      end else if (imem_req) begin
        if (!waiting) begin
          waiting = 1; gcnt = 0;
          gtarget = (gnt_delay < 0) ? $urandom_range(0, 3) : gnt_delay;
        end
        if (gcnt >= gtarget) begin
          imem_gnt = 1; waiting = 0; pend = 1; paddr = imem_addr;
          pwait = ((rsp_lat == 0) ? $urandom_range(1, 4) : rsp_lat) - 1;
          grants++;
          if (seq_chk) begin
            chk("fetch_addr_seq", imem_addr, seq_addr);
            seq_addr += 32'd4;
          end
        end else gcnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on every accept and checks handshake stability
  initial begin
    exp_t e;
    bit hold_prev, wait_prev, acc_prev;
    logic [31:0] hold_w, hold_pc, wait_addr;
    hold_prev = 0; wait_prev = 0; acc_prev = 0;
    hold_w = '0; hold_pc = '0; wait_addr = '0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        hold_prev = 0; wait_prev = 0; acc_prev = 0;
        continue;
      end
      if (hold_prev) begin
        chk("hold_valid", instr_valid, 1'b1);
        chk("hold_instr", instr, hold_w);
        chk("hold_pc", instr_pc, hold_pc);
      end
      if (wait_prev && !acc_prev) begin
        chk("req_held", imem_req, 1'b1);
        chk("addr_held", imem_addr, wait_addr);
      end
      if (instr_valid && instr_ready) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_accept actual_pc=%h required=none", instr_pc);
        end else begin
          e = sbq.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, e.w);
          chk("opcode", opcode, e.w[31:26]);
          chk("funct", funct, e.w[5:0]);
          if (e.pc == 32'h0000_3040 && ctrl_mode == 1) saw_target = 1;
        end
      end
      hold_prev = instr_valid && !instr_ready; hold_w = instr; hold_pc = instr_pc;
      wait_prev = imem_req && !imem_gnt; wait_addr = imem_addr;
      acc_prev = instr_valid && instr_ready;
    end
  end

  task automatic do_reset();
    @(negedge clk); #3;
    rst_n = 0;
    grants = 0; beq_done = 0;
    @(negedge clk); @(negedge clk); #3;
    rst_n = 1;
  endtask

  initial begin
    int a0;
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n;
    repeat (3) @(negedge clk);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, RPC);
    seq_chk = 1; seq_addr = RPC;
    #3 rst_n = 1;

    // Sequential fetch, zero-wait memory: one instruction every two cycles
    repeat (6) @(negedge clk);
    a0 = accepts;
    repeat (20) @(negedge clk);
    chk("throughput", accepts - a0, 10);
    seq_chk = 0;

    // Decode stalled after reset: exactly two requests fill the queue
    rdy_mode = 1;
    do_reset();
    repeat (10) @(negedge clk);
    chk("stall_grants", grants, 2);
    rdy_mode = 0;
    repeat (10) @(negedge clk);

    // beq to itself, then j to 0x3040
    ovr[32'h3000] = 32'h0000_0020;
    ovr[32'h3004] = {6'd4, 5'd1, 5'd2, 16'hFFFF};
    ovr[32'h3008] = {6'd2, 26'h000_0C10};
    ovr[32'h3040] = 32'h0000_0000;
    ctrl_mode = 1;
    do_reset();
    repeat (30) @(negedge clk);
    chk("reached_jump_target", saw_target, 1'b1);
    ctrl_mode = 0;

    // Slow memory: grant after 3 cycles, data 4 cycles after grant
    gnt_delay = 3; rsp_lat = 4;
    repeat (60) @(negedge clk);

    // Random handshakes and random redirects
    gnt_delay = -1; rsp_lat = 0; rdy_mode = 2; ctrl_mode = 2;
    repeat (3000) @(negedge clk);

    // Reset while a request is outstanding and the slot is occupied
    ctrl_mode = 0; rdy_mode = 1; gnt_delay = 0; rsp_lat = 4;
    do_reset();
    n = 0;
    while (!(instr_valid && pend) && n < 50) begin
      @(negedge clk); n++;
    end
    chk("busy_before_reset", instr_valid && pend, 1'b1);
    #3 rst_n = 0;
    #1;
    chk("async_rst_valid", instr_valid, 1'b0);
    chk("async_rst_req", imem_req, 1'b0);
    chk("async_rst_pc", instr_pc, RPC);
    grants = 0; seq_chk = 1; seq_addr = RPC;
    rdy_mode = 0; rsp_lat = 1;
    @(negedge clk); @(negedge clk); #3;
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("grants_after_reset", grants > 0, 1'b1);
    seq_chk = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
